// File: rtl/uart_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser_if
// Bundles the signals between the UART command parser, the UART RX FIFO and
// TX side, and the register file.
//   master : parser view (drives pops, tx requests, register strobes, status)
//   slave  : environment view (FIFO / UART / register file)
// Signals:
//   rx_irq, rx_byte   RX FIFO non-empty flag and head byte
//   rx_ren            one-cycle FIFO pop strobe
//   tx_byte, tx_valid byte to transmit and its one-cycle request
//   tx_done           one-cycle "byte sent" pulse from the UART
//   reg_addr, reg_wdata, reg_we, reg_re, reg_rdata   register access
//   busy, frame_err   status
// -----------------------------------------------------------------------------
interface uart_cmd_parser_if;
    logic        rx_irq;
    logic [7:0]  rx_byte;
    logic        rx_ren;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_done;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        busy;
    logic        frame_err;

    modport master (
        input  rx_irq, rx_byte, tx_done, reg_rdata,
        output rx_ren, tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re,
               busy, frame_err
    );

    modport slave (
        output rx_irq, rx_byte, tx_done, reg_rdata,
        input  rx_ren, tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re,
               busy, frame_err
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Turns bytes from a UART RX FIFO into register accesses.
//   Write frame: header 101x_xAAA followed by 4 data bytes (LSB first) -> reg_we
//   Read frame : any other header 'AAA' -> reg_re, then 4 response bytes sent
//                LSB first, each waiting for tx_done before the next.
// Ports:
//   clk         rising-edge clock
//   rst_n_sync  asynchronous active-low reset
//   if_bus      uart_cmd_parser_if.master (FIFO, UART TX, register bus, status)
// Parameter:
//   TIMEOUT_CYCLES  max idle cycles between bytes of a write frame
// Build option:
//   UART_CMD_TIMEOUT_EN  enables the inter-byte gap timeout and frame_err;
//                        without it frame_err is tied low and WDATA waits forever.
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n_sync,
    uart_cmd_parser_if.master if_bus
);

    typedef enum logic [2:0] {
        IDLE, WDATA, WCOMMIT, RREQ, RCAP, TXB, TXWAIT
    } state_t;

    state_t      r_state;
    logic        r_rx_ren;
    logic        r_tx_valid;
    logic        r_reg_we;
    logic        r_reg_re;
    logic [7:0]  r_tx_byte;
    logic [2:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        w_accept;
    logic        w_unused;

    // The FIFO head only advances after the pop cycle, so the cycle in which
    // rx_ren is high still shows the old byte: r_rx_ren doubles as pop guard.
    assign w_accept = if_bus.rx_irq && !r_rx_ren &&
                      (r_state == IDLE || r_state == WDATA);

    // Header bits [4:3] carry no meaning.
    assign w_unused = &{1'b0, if_bus.rx_byte[4:3]};

`ifdef UART_CMD_TIMEOUT_EN
    logic [15:0] r_gap;
    logic        r_frame_err;
    logic        w_timeout;

    // Gap count restarts on every accepted byte; fires on the edge where it
    // would reach TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after the pop.
    assign w_timeout = (r_gap == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync)
            r_gap <= 16'd0;
        else if (w_accept || r_state != WDATA)
            r_gap <= 16'd0;
        else
            r_gap <= r_gap + 16'd1;
    end

    assign if_bus.frame_err = r_frame_err;
`else
    assign if_bus.frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_state    <= IDLE;
            r_rx_ren   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_reg_we   <= 1'b0;
            r_reg_re   <= 1'b0;
            r_tx_byte  <= 8'd0;
            r_addr     <= 3'd0;
            r_wdata    <= 32'd0;
            r_shift    <= 32'd0;
            r_cnt      <= 2'd0;
`ifdef UART_CMD_TIMEOUT_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_rx_ren   <= w_accept;
            r_tx_valid <= 1'b0;
            r_reg_we   <= 1'b0;
            r_reg_re   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            r_frame_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= if_bus.rx_byte[2:0];
                        if (if_bus.rx_byte[7:5] == 3'b101) begin
                            r_wdata <= 32'd0;
                            r_cnt   <= 2'd0;
                            r_state <= WDATA;
                        end else begin
                            // reg_re is raised on entry so it is high for
                            // exactly the RREQ cycle; data arrives in RCAP.
                            r_reg_re <= 1'b1;
                            r_state  <= RREQ;
                        end
                    end
                end
                WDATA: begin
                    if (w_accept) begin
                        r_wdata[{r_cnt, 3'b000} +: 8] <= if_bus.rx_byte;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3)
                            r_state <= WCOMMIT;
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_wdata     <= 32'd0;
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end
`endif
                end
                WCOMMIT: begin
                    // Strobe lands the cycle after the last data pop.
                    r_reg_we <= 1'b1;
                    r_state  <= IDLE;
                end
                RREQ: r_state <= RCAP;
                RCAP: begin
                    r_shift <= if_bus.reg_rdata;
                    r_cnt   <= 2'd0;
                    r_state <= TXB;
                end
                TXB: begin
                    r_tx_valid <= 1'b1;
                    r_tx_byte  <= r_shift[7:0];
                    r_state    <= TXWAIT;
                end
                TXWAIT: begin
                    if (if_bus.tx_done) begin
                        r_shift <= {8'd0, r_shift[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        r_state <= (r_cnt == 2'd3) ? IDLE : TXB;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_bus.rx_ren    = r_rx_ren;
    assign if_bus.tx_valid  = r_tx_valid;
    assign if_bus.tx_byte   = r_tx_byte;
    assign if_bus.reg_we    = r_reg_we;
    assign if_bus.reg_re    = r_reg_re;
    assign if_bus.reg_addr  = r_addr;
    assign if_bus.reg_wdata = r_wdata;
    assign if_bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed bench: a small RX FIFO model feeds frames, register read data and
// tx_done are driven from the main sequence, and a monitor counts strobes.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst_n_sync;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .if_bus     (bus)
    );

    // RX FIFO model: pushes from the sequence, pops on rx_ren.
    logic [7:0] fmem [0:63];
    int wp = 0;
    int rp = 0;
    assign bus.rx_irq  = (wp != rp);
    assign bus.rx_byte = fmem[rp[5:0]];
    always @(posedge clk) if (bus.rx_ren && wp != rp) rp <= rp + 1;

    // Monitor
    int cyc = 0, ren_cnt = 0, we_cnt = 0, re_cnt = 0, tv_cnt = 0, fe_cnt = 0;
    int ov_cnt = 0, last_ren_cyc = 0, we_cyc = 0, fe_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rx_ren)    begin ren_cnt <= ren_cnt + 1; last_ren_cyc <= cyc; end
        if (bus.reg_we)    begin we_cnt  <= we_cnt + 1;  we_cyc <= cyc; end
        if (bus.reg_re)    re_cnt <= re_cnt + 1;
        if (bus.tx_valid)  tv_cnt <= tv_cnt + 1;
        if (bus.frame_err) begin fe_cnt <= fe_cnt + 1; fe_cyc <= cyc; end
        if ((bus.reg_we && bus.reg_re) || (bus.rx_ren && bus.tx_valid))
            ov_cnt <= ov_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return bus.reg_we;
            1: return bus.reg_re;
            2: return bus.tx_valid;
            3: return bus.frame_err;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int lim, input string tag);
        int n = 0;
        while (sig(sel) !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        if (sig(sel) !== 1'b1) check(tag, 32'(sig(sel)), 32'd1);
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wp[5:0]] = b;
        wp++;
    endtask

    task automatic check_reset(input string p);
        check({p, "_rx_ren"},    32'(bus.rx_ren),    32'd0);
        check({p, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
        check({p, "_reg_we"},    32'(bus.reg_we),    32'd0);
        check({p, "_reg_re"},    32'(bus.reg_re),    32'd0);
        check({p, "_busy"},      32'(bus.busy),      32'd0);
        check({p, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        check({p, "_tx_byte"},   32'(bus.tx_byte),   32'd0);
        check({p, "_reg_addr"},  32'(bus.reg_addr),  32'd0);
        check({p, "_reg_wdata"}, bus.reg_wdata,      32'd0);
    endtask

    task automatic apply_reset(input string p);
        @(negedge clk);
        #2 rst_n_sync = 1'b0;
        #1 check_reset(p);
        repeat (2) @(negedge clk);
        rst_n_sync = 1'b1;
        @(negedge clk);
    endtask

    // Serves one read: drives reg_rdata in the cycle after reg_re, checks the
    // four response bytes and that none is issued before the previous tx_done.
    task automatic serve_read(input logic [2:0] a, input logic [31:0] d,
                              input bit push_mid, input logic [7:0] mid);
        int ts;
        int snap;
        wait_sig(1, 60, "rd_re_wait");
        check("rd_addr", 32'(bus.reg_addr), 32'(a));
        check("rd_we_lo", 32'(bus.reg_we), 32'd0);
        @(posedge clk); #1 bus.reg_rdata = d;
        @(posedge clk); #1 bus.reg_rdata = 32'h0;
        @(negedge clk);
        ts   = tv_cnt;
        snap = ren_cnt;
        for (int i = 0; i < 4; i++) begin
            wait_sig(2, 20, "rd_tx_wait");
            check($sformatf("rd_tx_byte%0d", i), 32'(bus.tx_byte), 32'(d[8*i +: 8]));
            if (i == 0 && push_mid) push(mid);
            repeat (4) @(negedge clk);
            check($sformatf("rd_tx_hold%0d", i), 32'(tv_cnt - ts), 32'(i + 1));
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
        end
        check("rd_no_pop", 32'(ren_cnt - snap), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, q0, f0, n;
        rst_n_sync    = 1'b0;
        bus.tx_done   = 1'b0;
        bus.reg_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n_sync = 1'b1;
        repeat (2) @(negedge clk);

        // Stray tx_done in IDLE does nothing
        bus.tx_done = 1'b1; @(negedge clk); bus.tx_done = 1'b0;
        @(negedge clk);
        check("stray_busy", 32'(bus.busy), 32'd0);
        check("stray_txv",  32'(tv_cnt), 32'd0);

        // Write frame A5 78 56 34 12
        r0 = ren_cnt; w0 = we_cnt; q0 = re_cnt;
        push(8'hA5); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        wait_sig(0, 60, "wr_we_wait");
        check("wr_addr",  32'(bus.reg_addr), 32'd5);
        check("wr_data",  bus.reg_wdata, 32'h12345678);
        check("wr_re_lo", 32'(bus.reg_re), 32'd0);
        repeat (5) @(negedge clk);
        check("wr_we_cnt",  32'(we_cnt - w0), 32'd1);
        check("wr_pops",    32'(ren_cnt - r0), 32'd5);
        check("wr_latency", 32'(we_cyc - last_ren_cyc), 32'd1);
        check("wr_no_re",   32'(re_cnt - q0), 32'd0);
        check("wr_hold",    bus.reg_wdata, 32'h12345678);

        // Read frame 03 -> EF BE AD DE
        q0 = re_cnt; r0 = ren_cnt;
        push(8'h03);
        serve_read(3'd3, 32'hDEADBEEF, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("rd_busy",   32'(bus.busy), 32'd0);
        check("rd_re_cnt", 32'(re_cnt - q0), 32'd1);
        check("rd_pops",   32'(ren_cnt - r0), 32'd1);

        // Back-to-back: write reg0=1, read reg2; header 04 arrives mid-response
        w0 = we_cnt; r0 = ren_cnt;
        push(8'hA0); push(8'h01); push(8'h00); push(8'h00); push(8'h00); push(8'h02);
        wait_sig(0, 60, "b2b_we_wait");
        check("b2b_addr", 32'(bus.reg_addr), 32'd0);
        check("b2b_data", bus.reg_wdata, 32'h00000001);
        serve_read(3'd2, 32'hCAFEF00D, 1'b1, 8'h04);
        serve_read(3'd4, 32'h0BADF00D, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("b2b_we_cnt", 32'(we_cnt - w0), 32'd1);
        check("b2b_pops",   32'(ren_cnt - r0), 32'd7);

        // Partial write then silence
        w0 = we_cnt; f0 = fe_cnt;
        push(8'hA1); push(8'h11); push(8'h22);
`ifdef UART_CMD_TIMEOUT_EN
        wait_sig(3, 300, "to_fe_wait");
        check("to_fe_delay", 32'(fe_cyc - last_ren_cyc), 32'(TO));
        @(negedge clk);
        check("to_busy",   32'(bus.busy), 32'd0);
        check("to_fe_cnt", 32'(fe_cnt - f0), 32'd1);
        check("to_no_we",  32'(we_cnt - w0), 32'd0);
`else
        repeat (300) @(negedge clk);
        check("nto_busy",  32'(bus.busy), 32'd1);
        check("nto_fe",    32'(fe_cnt - f0), 32'd0);
        check("nto_no_we", 32'(we_cnt - w0), 32'd0);
        apply_reset("nto_rst");
`endif

        // Reset after two data bytes of a write frame
        w0 = we_cnt; r0 = ren_cnt; n = 0;
        push(8'hA5); push(8'h11); push(8'h22);
        while (ren_cnt - r0 < 3 && n < 50) begin @(negedge clk); n++; end
        check("mf_pops", 32'(ren_cnt - r0), 32'd3);
        apply_reset("mf");
        repeat (5) @(negedge clk);
        check("mf_no_we", 32'(we_cnt - w0), 32'd0);
        push(8'h01);
        serve_read(3'd1, 32'h89ABCDEF, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check("mf_busy", 32'(bus.busy), 32'd0);

        check("no_overlap", 32'(ov_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
